// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Arbitrates two packet requesters onto a single byte-wide UART transmitter.
// Each granted request is sent as a 4-byte packet:
//     HEADER, TAGn, payload[15:8], payload[7:0]
// Ties are resolved round-robin against the last granted requester. Each byte
// is handed over with a one-cycle tx_en strobe. The arbiter then waits for the
// transmitter to drop tx_status (byte taken), or for TIMEOUT cycles, and then
// for tx_status to rise again before the next byte.
//
// Parameters
//   HEADER   first byte of every packet
//   TAG0     second byte of packets from requester 0
//   TAG1     second byte of packets from requester 1
//   TIMEOUT  WAIT_LOW cycles after which a byte counts as accepted (1-255)
//
// Ports
//   sysclk     in   clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   req0       in   requester 0 request, held with data0 stable until gnt0
//   data0      in   requester 0 payload (16 bits)
//   req1       in   requester 1 request, held with data1 stable until gnt1
//   data1      in   requester 1 payload (16 bits)
//   tx_status  in   transmitter ready (1 = can accept a byte)
//   tx_data    out  byte to the transmitter, registered, held between loads
//   tx_en      out  one-cycle transmit strobe, registered
//   gnt0       out  one-cycle pulse: data0 captured
//   gnt1       out  one-cycle pulse: data1 captured
//   busy       out  high whenever the FSM is not IDLE (combinational)
//   done       out  one-cycle pulse after the last byte of a packet completes
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter logic [7:0]  HEADER  = 8'h0A,
    parameter logic [7:0]  TAG0    = 8'h01,
    parameter logic [7:0]  TAG1    = 8'h02,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    input  logic        tx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  idx;
    logic        lg;
    logic [7:0]  timer;
    logic [15:0] payload;
    logic [7:0]  cur_byte;

    // lg only changes on a grant, so while a packet is in flight it also
    // identifies the owner of that packet and selects the tag byte.
    always_comb begin
        cur_byte = HEADER;
        case (idx)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = lg ? TAG1 : TAG0;
            2'd2:    cur_byte = payload[15:8];
            default: cur_byte = payload[7:0];
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            timer   <= '0;
            lg      <= 1'b1;
            payload <= '0;
            tx_data <= '0;
            tx_en   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
        end else begin
            tx_en <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    // Requester 0 wins when alone, or on a tie when
                    // requester 1 had the previous grant.
                    if (req0 && (!req1 || lg)) begin
                        payload <= data0;
                        lg      <= 1'b0;
                        gnt0    <= 1'b1;
                        idx     <= '0;
                        state   <= ISSUE;
                    end else if (req1) begin
                        payload <= data1;
                        lg      <= 1'b1;
                        gnt1    <= 1'b1;
                        idx     <= '0;
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (tx_status) begin
                        tx_data <= cur_byte;
                        tx_en   <= 1'b1;
                        timer   <= '0;
                        state   <= WAIT_LOW;
                    end
                end

                WAIT_LOW: begin
                    // A transmitter that never drops ready is assumed to
                    // have taken the byte after TIMEOUT cycles here.
                    if (!tx_status || timer == TIMER_LAST) begin
                        state <= WAIT_HIGH;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end

                WAIT_HIGH: begin
                    if (tx_status) begin
                        if (idx != 2'd3) begin
                            idx   <= idx + 2'd1;
                            state <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A transaction-level model tracks
// whether a packet is in flight, the round-robin pointer and the queue of
// bytes each granted packet must produce. A behavioural transmitter drops
// ready for a chosen number of cycles after each strobe. Directed scenarios
// are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam logic [7:0] HEADER  = 8'h0A;
    localparam logic [7:0] TAG0    = 8'h01;
    localparam logic [7:0] TAG1    = 8'h02;
    localparam int         TIMEOUT = 15;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        req0;
    logic [15:0] data0;
    logic        req1;
    logic [15:0] data1;
    logic        tx_status;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;

    uart_tx_arbiter #(
        .HEADER  (HEADER),
        .TAG0    (TAG0),
        .TAG1    (TAG1),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .tx_status (tx_status),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .busy      (busy),
        .done      (done)
    );

    always #5 sysclk = ~sysclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    bit         in_pkt;
    bit         lg_m;
    logic [7:0] exp_q[$];
    logic [7:0] last_sent;
    int         nbytes;

    // Transmitter model
    int busy_len;
    int busy_left;
    bit rand_tx;
    bit tx_force;
    bit tx_force_val;

    // Event logs (cycle numbers / winners)
    int gnt_log[$];
    int who_log[$];
    int done_log[$];
    int en_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        in_pkt    = 1'b0;
        lg_m      = 1'b1;
        exp_q.delete();
        last_sent = 8'h00;
        nbytes    = 0;
        busy_left = 0;
    endfunction

    function automatic void clear_logs();
        gnt_log.delete();
        who_log.delete();
        done_log.delete();
        en_log.delete();
    endfunction

    // One clock: sample outputs 1 time unit after the edge, check against the
    // model using the inputs that were present at that edge, then drive the
    // next inputs.
    task automatic step();
        logic        p0, p1, prst;
        logic [15:0] pd0, pd1, d;
        bit          idle_before;
        bit          w;
        p0   = req0;
        p1   = req1;
        prst = reset;
        pd0  = data0;
        pd1  = data1;
        @(posedge sysclk);
        #1;
        cyc++;
        if (prst) begin
            check_eq("rst_tx_data", tx_data, 8'h00);
            check_eq("rst_tx_en", tx_en, 0);
            check_eq("rst_gnt0", gnt0, 0);
            check_eq("rst_gnt1", gnt1, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_busy", busy, 0);
            model_reset();
        end else begin
            idle_before = !in_pkt;
            if (done) begin
                check_eq("done_in_pkt", in_pkt, 1);
                check_eq("done_nbytes", nbytes, 4);
                in_pkt = 1'b0;
                done_log.push_back(cyc);
            end
            if (idle_before && (p0 || p1)) begin
                w = (p0 && p1) ? !lg_m : !p0;
                check_eq("gnt0", gnt0, !w);
                check_eq("gnt1", gnt1, w);
                d = w ? pd1 : pd0;
                in_pkt = 1'b1;
                lg_m   = w;
                nbytes = 0;
                exp_q.push_back(HEADER);
                exp_q.push_back(w ? TAG1 : TAG0);
                exp_q.push_back(d[15:8]);
                exp_q.push_back(d[7:0]);
                gnt_log.push_back(cyc);
                who_log.push_back(w);
            end else if (gnt0 || gnt1) begin
                check_eq("gnt_spurious", {gnt0, gnt1}, 0);
            end
            if (tx_en) begin
                check_eq("tx_en_in_pkt", in_pkt, 1);
                if (exp_q.size() == 0) begin
                    check_eq("tx_en_extra", exp_q.size(), 1);
                end else begin
                    last_sent = exp_q.pop_front();
                    nbytes++;
                end
                en_log.push_back(cyc);
            end
            check_eq("tx_data", tx_data, last_sent);
            check_eq("busy", busy, in_pkt);
        end

        if (tx_en) begin
            if (rand_tx) busy_left = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            else         busy_left = busy_len;
        end
        if (tx_force) begin
            tx_status = tx_force_val;
        end else if (busy_left > 0) begin
            tx_status = 1'b0;
            busy_left--;
        end else begin
            tx_status = 1'b1;
        end

        if (gnt0) begin
            req0  = 1'b0;
            data0 = 16'($urandom);
        end
        if (gnt1) begin
            req1  = 1'b0;
            data1 = 16'($urandom);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((req0 || req1 || in_pkt) && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_drain"}, {req0, req1, in_pkt}, 0);
        check_eq({tag, "_queue"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;
        reset        = 1'b1;
        req0         = 1'b0;
        req1         = 1'b0;
        data0        = '0;
        data1        = '0;
        tx_status    = 1'b1;
        busy_len     = 1;
        rand_tx      = 1'b0;
        tx_force     = 1'b0;
        tx_force_val = 1'b1;
        model_reset();

        // Reset values
        step();
        step();
        reset = 1'b0;
        step();

        // Single packet, ideal transmitter
        clear_logs();
        req0  = 1'b1;
        data0 = 16'hBEEF;
        drain("single", 200);
        repeat (3) step();
        check_eq("single_gnts", gnt_log.size(), 1);
        check_eq("single_dones", done_log.size(), 1);
        check_eq("single_bytes", en_log.size(), 4);

        // Tie from reset, back-to-back packets, then a second tie
        do_reset();
        clear_logs();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 16'($urandom);
        data1 = 16'h1234;
        drain("tie", 400);
        check_eq("tie_first", who_log[0], 0);
        check_eq("tie_second", who_log[1], 1);
        check_eq("tie_spacing", gnt_log[1] - gnt_log[0], 13);
        req0 = 1'b1;
        req1 = 1'b1;
        drain("tie2", 400);
        check_eq("tie2_first", who_log[2], 0);
        check_eq("tie2_second", who_log[3], 1);

        // Stall in ISSUE
        clear_logs();
        tx_force     = 1'b1;
        tx_force_val = 1'b0;
        req0  = 1'b1;
        data0 = 16'($urandom);
        n = 0;
        while (gnt_log.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check_eq("stall_gnt", gnt_log.size(), 1);
        repeat (20) begin
            step();
            check_eq("stall_tx_en", tx_en, 0);
        end
        tx_force = 1'b0;
        drain("stall", 200);
        check_eq("stall_bytes", en_log.size(), 4);

        // Timeout path: transmitter never drops ready
        clear_logs();
        tx_force     = 1'b1;
        tx_force_val = 1'b1;
        req1  = 1'b1;
        data1 = 16'($urandom);
        drain("tmo", 400);
        tx_force = 1'b0;
        check_eq("tmo_bytes", en_log.size(), 4);
        check_eq("tmo_done", done_log.size(), 1);
        if (en_log.size() == 4 && gnt_log.size() == 1 && done_log.size() == 1) begin
            check_eq("tmo_first", en_log[0] - gnt_log[0], 1);
            for (int i = 1; i < 4; i++) check_eq("tmo_period", en_log[i] - en_log[i-1], TIMEOUT + 2);
            check_eq("tmo_last", done_log[0] - en_log[3], TIMEOUT + 1);
        end

        // Reset after the second byte aborts the packet
        busy_len = 1;
        req0  = 1'b1;
        data0 = 16'($urandom);
        n = 0;
        while (!(in_pkt && nbytes >= 2) && n < 100) begin
            step();
            n++;
        end
        check_eq("abort_reached", nbytes, 2);
        do_reset();
        clear_logs();
        repeat (40) step();
        check_eq("abort_no_en", en_log.size(), 0);
        check_eq("abort_no_done", done_log.size(), 0);
        req1  = 1'b1;
        data1 = 16'($urandom);
        drain("post_abort", 200);
        check_eq("post_abort_who", who_log.size() > 0 ? who_log[0] : 0, 1);
        check_eq("post_abort_bytes", en_log.size(), 4);

        // Late request is held off until the arbiter is idle again
        clear_logs();
        req0  = 1'b1;
        data0 = 16'($urandom);
        n = 0;
        while (!(in_pkt && nbytes >= 1) && n < 100) begin
            step();
            n++;
        end
        req1  = 1'b1;
        data1 = 16'($urandom);
        drain("late", 400);
        ok = (gnt_log.size() == 2 && done_log.size() >= 1);
        check_eq("late_two_gnts", ok, 1);
        if (ok) check_eq("late_gnt_gap", gnt_log[1] - done_log[0], 1);

        // Randomized traffic with a randomized transmitter
        rand_tx = 1'b1;
        repeat (3000) begin
            if (!req0 && $urandom_range(0, 7) == 0) begin
                req0  = 1'b1;
                data0 = 16'($urandom);
            end
            if (!req1 && $urandom_range(0, 7) == 0) begin
                req1  = 1'b1;
                data1 = 16'($urandom);
            end
            step();
        end
        drain("random", 3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter HEADER, 8'h0A, first byte of every packet.
REQ-002 Parameter TAG0, 8'h01, second byte of packets from requester 0.
REQ-003 Parameter TAG1, 8'h02, second byte of packets from requester 1.
REQ-004 Parameter TIMEOUT, 15, maximum WAIT_LOW cycles before the byte is treated as accepted; range 1-255.
REQ-005 sysclk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req0  input  1  requester 0 packet request; held high with data0 stable until gnt0.
REQ-008 data0  input  16  requester 0 payload.
REQ-009 req1  input  1  requester 1 packet request; same rules as req0.
REQ-010 data1  input  16  requester 1 payload.
REQ-011 tx_status  input  1  UART transmitter idle/ready (1 = can accept byte).
REQ-012 tx_data  output  8  byte to transmitter, registered.
REQ-013 tx_en  output  1  one-cycle transmit strobe, registered.
REQ-014 gnt0  output  1  one-cycle pulse: data0 captured.
REQ-015 gnt1  output  1  one-cycle pulse: data1 captured.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse after last byte of a packet completes.

Function
REQ-018 Packet SHALL be 4 bytes in order: HEADER, TAGn, payload[15:8], payload[7:0].
REQ-019 States SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_HIGH; 2-bit byte index idx; 1-bit last-grant pointer lg.
REQ-020 IDLE, only req0 high: capture data0, lg<=0, gnt0=1 next cycle, idx<=0, go ISSUE.
REQ-021 IDLE, only req1 high: capture data1, lg<=1, gnt1=1 next cycle, idx<=0, go ISSUE.
REQ-022 IDLE, both high: grant requester !lg (round robin); other request stays pending, unacknowledged.
REQ-023 Requests in any state other than IDLE SHALL be ignored (no grant, no capture); gnt0 and gnt1 never both high.
REQ-024 ISSUE, tx_status=1: tx_data<=byte[idx], tx_en=1 for exactly the next cycle, timer<=0, go WAIT_LOW; tx_status=0: stay, tx_en=0.
REQ-025 tx_data SHALL hold its value until the next ISSUE load or reset.
REQ-026 WAIT_LOW: tx_status=0 -> WAIT_HIGH; else timer+1, and timer=TIMEOUT-1 -> WAIT_HIGH (byte treated as accepted).
REQ-027 WAIT_HIGH, tx_status=1: idx<3 -> idx+1, ISSUE; idx=3 -> done=1 next cycle, go IDLE.
REQ-028 WAIT_HIGH, tx_status=0: stay indefinitely.
REQ-029 Minimum IDLE-to-IDLE packet time with a transmitter that drops ready one cycle after tx_en: 4 x 3 + 1 cycles; a new grant SHALL be possible the cycle state returns to IDLE.
REQ-030 busy SHALL be combinational from state; all other outputs registered.
REQ-031 Payload SHALL be taken from the capture register, not live data inputs, for all four bytes.

Reset
REQ-032 reset=1 at a rising edge: state IDLE, idx 0, timer 0, lg 1 (requester 0 wins first tie), tx_data 8'h00, tx_en 0, gnt0 0, gnt1 0, done 0, capture register 0.
REQ-033 Reset mid-packet SHALL abort it: no further tx_en, no done, no retransmission after release.
REQ-034 reset has priority over all other inputs in the same cycle.

Verification
REQ-035 Single: req0=1, data0=16'hBEEF, ideal transmitter -> bytes 0A,01,BE,EF, one tx_en each, gnt0 once, done once, busy low after.
REQ-036 Tie: req0, req1 high together from reset, data1=16'h1234 -> packet 0A,01,.. first, then 0A,02,12,34; next tie grants req0 again.
REQ-037 Stall: hold tx_status=0 20 cycles in ISSUE -> tx_en stays 0, tx_data unchanged, then resumes on tx_status=1.
REQ-038 Timeout: tx_status stuck 1 -> each byte advances after TIMEOUT=15 WAIT_LOW cycles; all 4 bytes, done asserted.
REQ-039 Reset after byte 2 -> outputs to REQ-032 values next cycle; no further bytes; fresh req1 then sends full packet starting 0A.
REQ-040 Late request: req1 raised mid-packet of requester 0 -> no gnt1 until IDLE, then gnt1 the following cycle.
